register_file: RTL and testbench



---
 rtl/dma_pkg.sv | 37 +++
 rtl/regfile_alu.sv | 18 +
 rtl/register_file.sv | 77 +++++++
 tb/tb_register_file.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared opcode, transfer-type and address-map definitions
package dma_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 16;
  localparam int REG_IDX_W = 4;
  localparam int ADDR_W    = 8;

  // Instruction opcodes
  typedef enum logic [1:0] {
    OP_STORE = 2'b00,
    OP_LOAD  = 2'b01,
    OP_ADD   = 2'b10,
    OP_SUB   = 2'b11
  } op_e;

  // Transfer types
  typedef enum logic [1:0] {
    TY_MEM     = 2'b00,
    TY_IO_DMA  = 2'b01,
    TY_MEM2MEM = 2'b10,
    TY_REG_IO  = 2'b11
  } ty_e;

  // System address map: memory, then two I/O windows
  localparam logic [ADDR_W-1:0] MEM_MAX  = 8'd191;
  localparam logic [ADDR_W-1:0] IO1_BASE = 8'd192;
  localparam logic [ADDR_W-1:0] IO1_MAX  = 8'd223;
  localparam logic [ADDR_W-1:0] IO2_BASE = 8'd224;

  // True when a transfer of type ty touches the register file at address addr
  function automatic logic reg_xfer_ok(input logic [1:0] ty, input logic [ADDR_W-1:0] addr);
    return ((ty == TY_MEM)    && (addr <= MEM_MAX)) ||
           ((ty == TY_REG_IO) && (addr >= IO1_BASE));
  endfunction

endpackage

// File: rtl/regfile_alu.sv
// rtl/regfile_alu.sv - 32-bit add/subtract datapath, carry and borrow discarded
module regfile_alu
  import dma_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] y
);

  // op[0] selects subtract; result wraps modulo 2^32
  always_comb begin
    y = '0;
    if (sub) y = a - b;
    else     y = a + b;
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 16x32 register file with add/sub datapath and tri-state bus port
module register_file
  import dma_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output logic [DATA_W-1:0]    ReadData1,
  output logic [DATA_W-1:0]    ReadData2,
  input  logic [REG_IDX_W-1:0] Readreg1,
  input  logic [REG_IDX_W-1:0] Readreg2,
  input  logic [REG_IDX_W-1:0] Writereg,
  input  logic [ADDR_W-1:0]    source,
  input  logic [ADDR_W-1:0]    destination,
  input  logic                 RegWrite,
  input  logic [1:0]           op,
  // transfer type; "type" is a reserved word so the port carries a prefix
  input  logic [1:0]           xfer_type,
  inout  wire  [DATA_W-1:0]    data
);

  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              bus_drive;

  regfile_alu u_alu (
    .a   (ReadData1),
    .b   (ReadData2),
    .sub (op[0]),
    .y   (alu_y)
  );

  // Asynchronous read ports straight off the array
  always_comb begin
    ReadData1 = regs[Readreg1];
    ReadData2 = regs[Readreg2];
  end

  // Decide whether this instruction writes a register and with what
  always_comb begin
    wr_en   = 1'b0;
    wr_data = alu_y;
    case (op_e'(op))
      OP_ADD, OP_SUB: begin
        wr_en   = RegWrite;
        wr_data = alu_y;
      end
      OP_LOAD: begin
        // DMA / mem-to-mem and out-of-window loads bypass the register file
        wr_en   = RegWrite && reg_xfer_ok(xfer_type, source);
        wr_data = data;
      end
      default: begin
        wr_en   = 1'b0;
        wr_data = alu_y;
      end
    endcase
  end

  // Register array update; reset clears every entry and beats any pending write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[Writereg] <= wr_data;
    end
  end

  // Store data goes onto the bus only for stores into a valid window
  always_comb begin
    bus_drive = (op_e'(op) == OP_STORE) && reg_xfer_ok(xfer_type, destination);
  end

  assign data = bus_drive ? ReadData2 : {DATA_W{1'bz}};

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ReadData1, ReadData2;
  logic [3:0]  Readreg1, Readreg2, Writereg;
  logic [7:0]  source, destination;
  logic        RegWrite;
  logic [1:0]  op, xfer_type;
  wire  [31:0] data;

  logic        tb_en;
  logic [31:0] tb_val;

  assign data = tb_en ? tb_val : {32{1'bz}};

  always #5 clk = ~clk;

  register_file dut (
    .clk         (clk),
    .reset       (reset),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .Readreg1    (Readreg1),
    .Readreg2    (Readreg2),
    .Writereg    (Writereg),
    .source      (source),
    .destination (destination),
    .RegWrite    (RegWrite),
    .op          (op),
    .xfer_type   (xfer_type),
    .data        (data)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] BUS_PAT = 32'hA5A5A5A5;

  // Monitor: outputs are combinational, so sample every pending expectation mid-cycle
  always @(negedge clk) begin
    while (q.size() != 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        0:       act = ReadData1;
        1:       act = ReadData2;
        default: act = data;
      endcase
      tests++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] o, input logic [1:0] ty,
                       input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] w,
                       input logic we, input logic [7:0] src, input logic [7:0] dst,
                       input logic ben, input logic [31:0] bval);
    op = o; xfer_type = ty; Readreg1 = r1; Readreg2 = r2; Writereg = w;
    RegWrite = we; source = src; destination = dst; tb_en = ben; tb_val = bval;
  endtask

  // Let the monitor drain, then advance past the next rising edge
  task automatic step();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL monitor_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read2(input string name, input logic [3:0] r1, input logic [31:0] v1,
                       input logic [3:0] r2, input logic [31:0] v2);
    drive(2'b01, 2'b01, r1, r2, 4'd0, 1'b0, 8'd0, 8'd0, 1'b0, 32'h0);
    expect_val({name, "_rd1"}, 0, v1);
    expect_val({name, "_rd2"}, 1, v2);
    step();
  endtask

  task automatic load(input logic [3:0] w, input logic [31:0] v);
    drive(2'b01, 2'b00, 4'd0, 4'd0, w, 1'b1, 8'd0, 8'd0, 1'b1, v);
    step();
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b01, 2'b00, 4'd0, 4'd15, 4'd0, 1'b0, 8'd0, 8'd0, 1'b0, 32'h0);
    #1;
    expect_val("reset_rd1", 0, 32'h0);
    expect_val("reset_rd2", 1, 32'h0);
    step();
    reset = 1'b0;
    step();

    // ALU
    load(4'd1, 32'd5);
    load(4'd2, 32'd7);
    drive(2'b10, 2'b00, 4'd1, 4'd2, 4'd3, 1'b1, 8'd0, 8'd0, 1'b0, 32'h0);
    expect_val("add_opa", 0, 32'd5);
    expect_val("add_opb", 1, 32'd7);
    step();
    drive(2'b11, 2'b00, 4'd1, 4'd2, 4'd4, 1'b1, 8'd0, 8'd0, 1'b0, 32'h0);
    step();
    read2("alu_result", 4'd3, 32'd12, 4'd4, 32'hFFFFFFFE);

    // Load qualification
    drive(2'b01, 2'b00, 4'd0, 4'd0, 4'd5, 1'b1, 8'd10, 8'd0, 1'b1, 32'hDEADBEEF);
    step();
    read2("ld_mem", 4'd5, 32'hDEADBEEF, 4'd0, 32'h0);
    drive(2'b01, 2'b00, 4'd0, 4'd0, 4'd5, 1'b1, 8'd200, 8'd0, 1'b1, 32'h11111111);
    step();
    read2("ld_mem_oor", 4'd5, 32'hDEADBEEF, 4'd0, 32'h0);
    drive(2'b01, 2'b11, 4'd0, 4'd0, 4'd5, 1'b1, 8'd200, 8'd0, 1'b1, 32'hCAFEF00D);
    step();
    read2("ld_io", 4'd5, 32'hCAFEF00D, 4'd0, 32'h0);
    drive(2'b01, 2'b00, 4'd0, 4'd0, 4'd8, 1'b1, 8'd191, 8'd0, 1'b1, 32'h00000191);
    step();
    drive(2'b01, 2'b11, 4'd0, 4'd0, 4'd8, 1'b1, 8'd191, 8'd0, 1'b1, 32'h00000BAD);
    step();
    read2("ld_edge191", 4'd8, 32'h00000191, 4'd0, 32'h0);
    drive(2'b01, 2'b11, 4'd0, 4'd0, 4'd8, 1'b1, 8'd192, 8'd0, 1'b1, 32'h00000192);
    step();
    read2("ld_edge192", 4'd8, 32'h00000192, 4'd0, 32'h0);

    // Store drive; where the DUT must release the bus, the bench drives a pattern
    // that would be corrupted by any contending driver
    load(4'd6, 32'h12345678);
    drive(2'b00, 2'b00, 4'd0, 4'd6, 4'd9, 1'b1, 8'd0, 8'd50, 1'b0, 32'h0);
    expect_val("st_mem50", 2, 32'h12345678);
    step();
    drive(2'b00, 2'b00, 4'd0, 4'd6, 4'd9, 1'b1, 8'd0, 8'd191, 1'b0, 32'h0);
    expect_val("st_mem191", 2, 32'h12345678);
    step();
    drive(2'b00, 2'b00, 4'd0, 4'd6, 4'd9, 1'b1, 8'd0, 8'd192, 1'b1, BUS_PAT);
    expect_val("st_mem192_z", 2, BUS_PAT);
    step();
    drive(2'b00, 2'b00, 4'd0, 4'd6, 4'd9, 1'b1, 8'd0, 8'd230, 1'b1, BUS_PAT);
    expect_val("st_mem230_z", 2, BUS_PAT);
    step();
    drive(2'b00, 2'b11, 4'd0, 4'd6, 4'd9, 1'b1, 8'd0, 8'd230, 1'b0, 32'h0);
    expect_val("st_io230", 2, 32'h12345678);
    step();
    drive(2'b00, 2'b11, 4'd0, 4'd6, 4'd9, 1'b1, 8'd0, 8'd100, 1'b1, BUS_PAT);
    expect_val("st_io100_z", 2, BUS_PAT);
    step();
    read2("st_nowrite", 4'd9, 32'h0, 4'd6, 32'h12345678);

    // DMA / mem-to-mem loads leave registers alone and never drive the bus
    drive(2'b01, 2'b01, 4'd0, 4'd6, 4'd6, 1'b1, 8'd10, 8'd10, 1'b1, BUS_PAT);
    expect_val("dma_z", 2, BUS_PAT);
    step();
    drive(2'b01, 2'b10, 4'd0, 4'd6, 4'd6, 1'b1, 8'd10, 8'd10, 1'b1, BUS_PAT);
    expect_val("m2m_z", 2, BUS_PAT);
    step();
    read2("dma_nowrite", 4'd6, 32'h12345678, 4'd5, 32'hCAFEF00D);

    // Read during write
    drive(2'b01, 2'b00, 4'd7, 4'd0, 4'd7, 1'b1, 8'd0, 8'd0, 1'b1, 32'd9);
    expect_val("rdw_old", 0, 32'h0);
    step();
    read2("rdw_new", 4'd7, 32'd9, 4'd0, 32'h0);
    drive(2'b10, 2'b00, 4'd1, 4'd2, 4'd1, 1'b1, 8'd0, 8'd0, 1'b0, 32'h0);
    step();
    read2("rdw_add_self", 4'd1, 32'd12, 4'd2, 32'd7);

    // Reset mid-cycle with a load pending
    drive(2'b01, 2'b00, 4'd6, 4'd5, 4'd6, 1'b1, 8'd0, 8'd0, 1'b1, BUS_PAT);
    reset = 1'b1;
    #1;
    expect_val("rst_rd1", 0, 32'h0);
    expect_val("rst_rd2", 1, 32'h0);
    expect_val("rst_bus_z", 2, BUS_PAT);
    step();
    reset = 1'b0;
    read2("rst_cleared", 4'd6, 32'h0, 4'd1, 32'h0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
